// File: rtl/reg_sched_pkg.sv
// Shared constants and debug types for the register-write scoreboard.
package reg_sched_pkg;

    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 1 << ADDR_W;
    localparam int REG_ZERO = 0;

    // Why an issue is being held back; NONE means it may go.
    typedef enum logic [1:0] {
        NONE = 2'd0,
        RAW  = 2'd1,
        WAW  = 2'd2,
        FULL = 2'd3
    } hazard_cause_e;

endpackage

// File: rtl/reg_scoreboard_hazard_check.sv
// Combinational issue gate: decides from the registered pending vector whether
// the presented instruction may issue, and reports the blocking cause.
module hazard_check #(
    parameter int ADDR_W   = reg_sched_pkg::ADDR_W,
    parameter int NUM_REGS = reg_sched_pkg::NUM_REGS
) (
    input  logic [NUM_REGS-1:0]          pending,
    input  logic [ADDR_W-1:0]            src_a,
    input  logic [ADDR_W-1:0]            src_b,
    input  logic                         uses_b,
    input  logic [ADDR_W-1:0]            dest,
    input  logic                         writes,
    input  logic                         at_limit,
    output logic                         ready,
    output reg_sched_pkg::hazard_cause_e cause
);
    import reg_sched_pkg::*;

    logic tracked;
    logic raw_hit;
    logic waw_hit;
    logic full_hit;

    // r0 is never pending, so a read of r0 can never raise a RAW hazard.
    assign tracked  = writes && (dest != ADDR_W'(REG_ZERO));
    assign raw_hit  = pending[src_a] || (uses_b && pending[src_b]);
    assign waw_hit  = tracked && pending[dest];
    assign full_hit = tracked && at_limit;
    assign ready    = !(raw_hit || waw_hit || full_hit);

    always_comb begin
        cause = NONE;
        if (raw_hit) begin
            cause = RAW;
        end else if (waw_hit) begin
            cause = WAW;
        end else if (full_hit) begin
            cause = FULL;
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// Register-write scoreboard: tracks in-flight writes per register and gates
// instruction issue on RAW/WAW hazards and the outstanding-write limit.
module reg_scoreboard #(
    parameter int ADDR_W          = reg_sched_pkg::ADDR_W,
    parameter int NUM_REGS        = reg_sched_pkg::NUM_REGS,
    parameter int MAX_OUTSTANDING = 8,
    parameter int CNT_W           = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               issue_valid,
    input  logic [ADDR_W-1:0]                  issue_src_a,
    input  logic [ADDR_W-1:0]                  issue_src_b,
    input  logic                               issue_uses_b,
    input  logic [ADDR_W-1:0]                  issue_dest,
    input  logic                               issue_writes,
    output logic                               issue_ready,
    input  logic                               wb_valid,
    input  logic [ADDR_W-1:0]                  wb_addr,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] pending_count,
    output logic                               idle,
    output logic [CNT_W-1:0]                   stall_cycles,
    output logic                               wb_err
);
    import reg_sched_pkg::*;

    localparam int PC_W = $clog2(MAX_OUTSTANDING + 1);

    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pending_next;
    logic                at_limit;
    logic                set_en;
    logic                wb_live;
    logic                wb_hit;
    logic                wb_miss;
    hazard_cause_e       hazard_cause;

    assign at_limit = (pending_count == PC_W'(MAX_OUTSTANDING));
    assign idle     = (pending_count == '0);

    hazard_check #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_hazard (
        .pending  (pending),
        .src_a    (issue_src_a),
        .src_b    (issue_src_b),
        .uses_b   (issue_uses_b),
        .dest     (issue_dest),
        .writes   (issue_writes),
        .at_limit (at_limit),
        .ready    (issue_ready),
        .cause    (hazard_cause)
    );

    assign set_en  = issue_valid && issue_ready && issue_writes
                     && (issue_dest != ADDR_W'(REG_ZERO));
    assign wb_live = wb_valid && (wb_addr != ADDR_W'(REG_ZERO));
    assign wb_hit  = wb_live && pending[wb_addr];
    assign wb_miss = wb_live && !pending[wb_addr];

    // Clear is applied before set so an illegal same-register collision leaves the bit set.
    always_comb begin
        pending_next = pending;
        if (wb_hit) begin
            pending_next[wb_addr] = 1'b0;
        end
        if (set_en) begin
            pending_next[issue_dest] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending       <= '0;
            pending_count <= '0;
            stall_cycles  <= '0;
            wb_err        <= 1'b0;
        end else begin
            pending <= pending_next;
            case ({set_en, wb_hit})
                2'b10:   pending_count <= pending_count + 1'b1;
                2'b01:   pending_count <= pending_count - 1'b1;
                default: pending_count <= pending_count;
            endcase
            if (wb_miss) begin
                wb_err <= 1'b1;
            end
            if (issue_valid && !issue_ready && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (pending_count == PC_W'($countones(pending)));
            assert (!pending[0]);
            assert (issue_ready == (hazard_cause == NONE));
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench for reg_scoreboard: directed hazard scenarios followed by a
// randomized mix, checked against a per-register behavioural model.
module tb_reg_scoreboard;

    localparam int AW    = 5;
    localparam int NR    = 32;
    localparam int MAXO  = 8;
    localparam int CW    = 4;
    localparam int SMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          issue_valid = 1'b0;
    logic [AW-1:0] issue_src_a = '0;
    logic [AW-1:0] issue_src_b = '0;
    logic          issue_uses_b = 1'b0;
    logic [AW-1:0] issue_dest = '0;
    logic          issue_writes = 1'b0;
    logic          issue_ready;
    logic          wb_valid = 1'b0;
    logic [AW-1:0] wb_addr = '0;
    logic [$clog2(MAXO+1)-1:0] pending_count;
    logic          idle;
    logic [CW-1:0] stall_cycles;
    logic          wb_err;

    reg_scoreboard #(
        .ADDR_W          (AW),
        .NUM_REGS        (NR),
        .MAX_OUTSTANDING (MAXO),
        .CNT_W           (CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .issue_valid   (issue_valid),
        .issue_src_a   (issue_src_a),
        .issue_src_b   (issue_src_b),
        .issue_uses_b  (issue_uses_b),
        .issue_dest    (issue_dest),
        .issue_writes  (issue_writes),
        .issue_ready   (issue_ready),
        .wb_valid      (wb_valid),
        .wb_addr       (wb_addr),
        .pending_count (pending_count),
        .idle          (idle),
        .stall_cycles  (stall_cycles),
        .wb_err        (wb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit ready;
        int cnt;
        bit err;
        int stall;
        int want_r;
        int want_c;
        int want_e;
    } exp_t;

    exp_t sb_q[$];

    // Reference model: one flag per register plus the sticky error and stall counter.
    bit m_pend[NR];
    bit m_err;
    int m_stall;

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int popcnt();
        int n = 0;
        for (int r = 0; r < NR; r++) n += m_pend[r] ? 1 : 0;
        return n;
    endfunction

    function automatic bit model_ready(input int sa, input int sb, input bit ub, input int d, input bit w);
        bit blocked;
        blocked = m_pend[sa] || (ub && m_pend[sb]);
        if (w && d != 0 && (m_pend[d] || popcnt() == MAXO)) blocked = 1'b1;
        return !blocked;
    endfunction

    task automatic step(input bit rn, input bit iv, input int sa, input int sb, input bit ub,
                        input int d, input bit w, input bit wv, input int wa,
                        input int want_r, input int want_c, input int want_e);
        exp_t e;
        bit   rdy;
        @(posedge clk);
        #1;
        rst_n        = rn;
        issue_valid  = iv;
        issue_src_a  = AW'(sa);
        issue_src_b  = AW'(sb);
        issue_uses_b = ub;
        issue_dest   = AW'(d);
        issue_writes = w;
        wb_valid     = wv;
        wb_addr      = AW'(wa);
        rdy = model_ready(sa, sb, ub, d, w);
        e.ready = rdy;
        e.cnt = popcnt();
        e.err = m_err;
        e.stall = m_stall;
        e.want_r = want_r;
        e.want_c = want_c;
        e.want_e = want_e;
        sb_q.push_back(e);
        if (!rn) begin
            for (int r = 0; r < NR; r++) m_pend[r] = 1'b0;
            m_err = 1'b0;
            m_stall = 0;
        end else begin
            if (iv && !rdy && m_stall < SMAX) m_stall++;
            if (wv && wa != 0) begin
                if (m_pend[wa]) m_pend[wa] = 1'b0;
                else m_err = 1'b1;
            end
            if (iv && rdy && w && d != 0) m_pend[d] = 1'b1;
        end
    endtask

    task automatic iss(input int sa, input bit ub, input int sb, input int d, input bit w,
                       input int want_r, input int want_c);
        step(1, 1, sa, sb, ub, d, w, 0, 0, want_r, want_c, -1);
    endtask

    task automatic wbk(input int a, input int want_c, input int want_e);
        step(1, 0, 0, 0, 0, 0, 0, 1, a, -1, want_c, want_e);
    endtask

    task automatic nop(input int want_c, input int want_e);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, -1, want_c, want_e);
    endtask

    // Monitor: pops one expectation for every presented cycle and compares.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("ready", int'(issue_ready), int'(e.ready));
                chk("pending_count", int'(pending_count), e.cnt);
                chk("idle", int'(idle), (e.cnt == 0) ? 1 : 0);
                chk("stall_cycles", int'(stall_cycles), e.stall);
                chk("wb_err", int'(wb_err), int'(e.err));
                if (e.want_r >= 0) chk("dir_ready", int'(issue_ready), e.want_r);
                if (e.want_c >= 0) chk("dir_count", int'(pending_count), e.want_c);
                if (e.want_e >= 0) chk("dir_wb_err", int'(wb_err), e.want_e);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int pl[$];
        bit iv, ub, w, wv, rn;
        int sa, sb, d, wa;

        for (int r = 0; r < NR; r++) m_pend[r] = 1'b0;
        m_err = 1'b0;
        m_stall = 0;
        @(posedge clk);

        // Reset then idle
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        nop(0, 0);

        // RAW stall and one-cycle release after write-back
        iss(0, 0, 0, 5, 1, 1, 0);
        iss(5, 0, 0, 0, 0, 0, 1);
        step(1, 1, 5, 0, 0, 0, 0, 1, 5, 0, 1, 0);
        iss(5, 0, 0, 0, 0, 1, 0);

        // WAW, then r0 writes and r0 reads
        iss(0, 0, 0, 7, 1, 1, 0);
        iss(0, 0, 0, 7, 1, 0, 1);
        wbk(7, 1, 0);
        for (int i = 0; i < 3; i++) iss(0, 0, 0, 0, 1, 1, 0);
        iss(0, 1, 0, 0, 1, 1, 0);

        // Outstanding limit
        for (int i = 1; i <= 8; i++) iss(0, 0, 0, i, 1, 1, i - 1);
        iss(0, 0, 0, 9, 1, 0, 8);
        iss(20, 0, 0, 0, 0, 1, 8);
        step(1, 1, 0, 0, 0, 9, 1, 1, 3, 0, 8, 0);
        iss(0, 0, 0, 9, 1, 1, 7);
        nop(8, 0);
        foreach (pl[i]) pl.delete(i);
        pl = '{1, 2, 4, 5, 6, 7, 8, 9};
        for (int i = 0; i < 8; i++) wbk(pl[i], 8 - i, 0);

        // Sticky write-back error
        wbk(12, 0, 0);
        nop(0, 1);
        iss(0, 0, 0, 4, 1, 1, 0);
        wbk(4, 1, 1);
        wbk(0, 0, 1);
        nop(0, 1);

        // Mid-operation reset discards pending writes
        iss(0, 0, 0, 10, 1, 1, 0);
        iss(0, 0, 0, 11, 1, 1, 1);
        iss(0, 0, 0, 13, 1, 1, 2);
        iss(0, 0, 0, 14, 1, 1, 3);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, -1, 4, 1);
        wbk(10, 0, 0);
        nop(0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, -1, -1, -1);

        // Random mix
        for (int c = 0; c < 5000; c++) begin
            rn = ($urandom_range(0, 599) != 0);
            iv = ($urandom_range(0, 9) < 7);
            sa = $urandom_range(0, 12);
            sb = $urandom_range(0, 12);
            ub = $urandom_range(0, 1);
            d  = $urandom_range(0, 12);
            w  = ($urandom_range(0, 3) != 0);
            wv = ($urandom_range(0, 9) < 4);
            pl.delete();
            for (int r = 1; r < NR; r++) if (m_pend[r]) pl.push_back(r);
            if (pl.size() > 0 && $urandom_range(0, 15) != 0)
                wa = pl[$urandom_range(0, pl.size() - 1)];
            else
                wa = $urandom_range(0, NR - 1);
            step(rn, iv, sa, sb, ub, d, w, wv, wa, -1, -1, -1);
        end

        repeat (2) @(posedge clk);
        chk("queue_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
